node_delete_filter: RTL and testbench

Streaming genome filter for the PE's delete-node mutation path. It sits immediately upstream of the deleted-node table and is the only agent that writes to it. Node genes marked for deletion are removed from the stream and recorded in the table. Connection genes are checked against the table, and any connection whose source or destination node was deleted is dropped. All other genes pass through to the downstream crossover/writeback stage.

---
 rtl/node_delete_filter.sv | 124 ++++++++++++
 tb/tb_node_delete_filter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/node_delete_filter.sv
// Streaming delete-node filter: drops deleted node genes (recording them in the table)
// and connections touching deleted nodes; 1-cycle pass-through, stalls input while output is held.
module node_delete_filter #(
    parameter int DATA_WIDTH   = 8,
    parameter int WEIGHT_WIDTH = 16,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_is_conn,
    input  logic                    in_del,
    input  logic [DATA_WIDTH-1:0]   in_id1,
    input  logic [DATA_WIDTH-1:0]   in_id2,
    input  logic [WEIGHT_WIDTH-1:0] in_weight,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_is_conn,
    output logic [DATA_WIDTH-1:0]   out_id1,
    output logic [DATA_WIDTH-1:0]   out_id2,
    output logic [WEIGHT_WIDTH-1:0] out_weight,
    output logic                    out_last,
    output logic                    tbl_rst,
    output logic                    tbl_add,
    output logic                    tbl_conn,
    output logic [DATA_WIDTH-1:0]   tbl_node_id1,
    output logic [DATA_WIDTH-1:0]   tbl_node_id2,
    input  logic                    tbl_match,
    input  logic                    tbl_full,
    output logic [CNT_WIDTH-1:0]    del_count,
    output logic [CNT_WIDTH-1:0]    drop_count,
    output logic [CNT_WIDTH-1:0]    del_refused
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [2:0] state;
    logic       accept;
    logic       del_req;
    logic       drop_conn;
    logic       refuse;
    logic       pass;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_ONE;
    endfunction

    assign busy    = (state != S_IDLE);
    assign done    = (state == S_DONE);
    assign tbl_rst = (state == S_CLEAR);

    // Backpressure applies even to genes that would be dropped, keeping acceptance simple.
    assign in_ready = (state == S_RUN) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    assign tbl_node_id1 = in_id1;
    assign tbl_node_id2 = in_is_conn ? in_id2 : in_id1;
    assign tbl_conn     = in_is_conn;

    assign del_req   = !in_is_conn && in_del;
    assign tbl_add   = accept && del_req && !tbl_full;
    assign refuse    = accept && del_req && tbl_full;
    assign drop_conn = accept && in_is_conn && tbl_match;
    assign pass      = accept && !tbl_add && !drop_conn;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (start) state <= S_CLEAR;
                S_CLEAR: state <= S_RUN;
                S_RUN:   if (accept && in_last) state <= S_DRAIN;
                S_DRAIN: if (!out_valid) state <= S_DONE;
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_is_conn <= 1'b0;
            out_id1     <= '0;
            out_id2     <= '0;
            out_weight  <= '0;
            out_last    <= 1'b0;
        end else if (pass) begin
            out_valid   <= 1'b1;
            out_is_conn <= in_is_conn;
            out_id1     <= in_id1;
            out_id2     <= in_id2;
            out_weight  <= in_weight;
            out_last    <= in_last;
        end else if (out_ready) begin
            out_valid   <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || state == S_CLEAR) begin
            del_count   <= '0;
            drop_count  <= '0;
            del_refused <= '0;
        end else begin
            if (tbl_add)   del_count   <= sat_inc(del_count);
            if (drop_conn) drop_count  <= sat_inc(drop_count);
            if (refuse)    del_refused <= sat_inc(del_refused);
        end
    end

endmodule

// File: tb/tb_node_delete_filter.sv
// Scoreboard bench for node_delete_filter with an 8-entry deleted-node table model.
module tb_node_delete_filter;

    typedef struct packed {
        logic       is_conn;
        logic [7:0] id1;
        logic [7:0] id2;
        logic [15:0] w;
        logic       last;
    } gene_t;

    logic        clk = 1'b0;
    logic        rst, start, busy, done;
    logic        in_valid, in_ready, in_is_conn, in_del, in_last;
    logic [7:0]  in_id1, in_id2;
    logic [15:0] in_weight;
    logic        out_valid, out_ready, out_is_conn, out_last;
    logic [7:0]  out_id1, out_id2;
    logic [15:0] out_weight;
    logic        tbl_rst, tbl_add, tbl_conn, tbl_match, tbl_full;
    logic [7:0]  tbl_node_id1, tbl_node_id2;
    logic [15:0] del_count, drop_count, del_refused;

    int checks = 0;
    int errors = 0;
    gene_t exp_q[$];
    logic [7:0] add_q[$];

    logic [7:0] tbl_mem [8];
    int tbl_cnt = 0;

    always #5 clk = ~clk;

    node_delete_filter #(.DATA_WIDTH(8), .WEIGHT_WIDTH(16), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .in_valid(in_valid), .in_ready(in_ready), .in_is_conn(in_is_conn), .in_del(in_del),
        .in_id1(in_id1), .in_id2(in_id2), .in_weight(in_weight), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_is_conn(out_is_conn),
        .out_id1(out_id1), .out_id2(out_id2), .out_weight(out_weight), .out_last(out_last),
        .tbl_rst(tbl_rst), .tbl_add(tbl_add), .tbl_conn(tbl_conn),
        .tbl_node_id1(tbl_node_id1), .tbl_node_id2(tbl_node_id2),
        .tbl_match(tbl_match), .tbl_full(tbl_full),
        .del_count(del_count), .drop_count(drop_count), .del_refused(del_refused)
    );

    // Deleted-node table: writes land at the edge, lookups are combinational.
    always @(posedge clk) begin
        if (tbl_rst) begin
            tbl_cnt <= 0;
        end else if (tbl_add && !tbl_conn && tbl_cnt < 8) begin
            tbl_mem[tbl_cnt] <= tbl_node_id1;
            tbl_cnt <= tbl_cnt + 1;
        end
    end

    always_comb begin
        tbl_match = 1'b0;
        for (int i = 0; i < 8; i++)
            if (i < tbl_cnt && (tbl_mem[i] == tbl_node_id1 || tbl_mem[i] == tbl_node_id2))
                tbl_match = 1'b1;
    end
    assign tbl_full = (tbl_cnt == 8);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: pops the scoreboard on every output handshake and every table write.
    initial begin
        gene_t act;
        forever begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                act = {out_is_conn, out_id1, out_id2, out_weight, out_last};
                if (exp_q.size() == 0) check("unexpected_out", 64'(act), 64'h0);
                else check("out_gene", 64'(act), 64'(exp_q.pop_front()));
            end
            if (tbl_add) begin
                if (add_q.size() == 0) check("unexpected_tbl_add", 64'(tbl_node_id1), 64'hff00);
                else check("tbl_add_id", 64'(tbl_node_id1), 64'(add_q.pop_front()));
            end
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic c, input logic d, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] w, input logic l, input logic passes);
        int n;
        logic ok;
        in_valid = 1'b1; in_is_conn = c; in_del = d; in_id1 = a; in_id2 = b;
        in_weight = w; in_last = l;
        if (passes) exp_q.push_back('{c, a, b, w, l});
        n = 0; ok = 1'b0;
        while (!ok && n < 100) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!ok) check("accept_timeout", 64'(ok), 64'h1);
        in_valid = 1'b0;
    endtask

    task automatic start_pass;
        start = 1'b1;
        step();
        start = 1'b0;
        @(negedge clk);
        check("tbl_rst_on", 64'(tbl_rst), 64'h1);
        @(negedge clk);
        check("tbl_rst_one_cycle", 64'(tbl_rst), 64'h0);
        step();
    endtask

    task automatic wait_done;
        int n;
        logic got;
        n = 0; got = 1'b0;
        while (!got && n < 200) begin
            @(negedge clk);
            got = done;
            n++;
        end
        check("done_seen", 64'(got), 64'h1);
        check("sb_empty_at_done", 64'(exp_q.size()), 64'h0);
        check("adds_empty_at_done", 64'(add_q.size()), 64'h0);
        @(negedge clk);
        check("done_pulse_ends", 64'(done), 64'h0);
        check("idle_after_done", 64'(busy), 64'h0);
        step();
    endtask

    task automatic check_counters(input int d, input int dr, input int rf);
        check("del_count", 64'(del_count), 64'(d));
        check("drop_count", 64'(drop_count), 64'(dr));
        check("del_refused", 64'(del_refused), 64'(rf));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_is_conn = 1'b0; in_del = 1'b0;
        in_id1 = '0; in_id2 = '0; in_weight = '0; in_last = 1'b0; out_ready = 1'b1;
        repeat (3) step();
        @(negedge clk);
        check("rst_busy", 64'(busy), 64'h0);
        check("rst_done", 64'(done), 64'h0);
        check("rst_out_valid", 64'(out_valid), 64'h0);
        check("rst_in_ready", 64'(in_ready), 64'h0);
        check("rst_tbl_rst", 64'(tbl_rst), 64'h0);
        check_counters(0, 0, 0);
        step();
        rst = 1'b0;

        // in_valid while idle must not be consumed
        in_valid = 1'b1; in_is_conn = 1'b0; in_id1 = 8'd99; in_last = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("idle_in_ready", 64'(in_ready), 64'h0);
            check("idle_busy", 64'(busy), 64'h0);
        end
        step();
        in_valid = 1'b0;

        // pass-through
        start_pass();
        for (int i = 1; i <= 4; i++) send(1'b0, 1'b0, 8'(i), 8'd0, 16'(16'h100 + i), 1'b0, 1'b1);
        send(1'b1, 1'b0, 8'd1, 8'd3, 16'h0013, 1'b0, 1'b1);
        send(1'b1, 1'b0, 8'd2, 8'd4, 16'h0024, 1'b1, 1'b1);
        wait_done();
        check_counters(0, 0, 0);

        // delete + dependent drop, with a start pulse mid-pass
        start_pass();
        add_q.push_back(8'd5);
        send(1'b0, 1'b1, 8'd5, 8'd0, 16'h0205, 1'b0, 1'b0);
        start = 1'b1;
        @(negedge clk);
        check("start_busy_no_clear", 64'(tbl_rst), 64'h0);
        check("start_busy_still_busy", 64'(busy), 64'h1);
        step();
        start = 1'b0;
        send(1'b0, 1'b0, 8'd6, 8'd0, 16'h0206, 1'b0, 1'b1);
        send(1'b1, 1'b1, 8'd5, 8'd6, 16'h0256, 1'b0, 1'b0);
        send(1'b1, 1'b0, 8'd6, 8'd7, 16'h0267, 1'b0, 1'b1);
        send(1'b1, 1'b0, 8'd7, 8'd5, 16'h0275, 1'b1, 1'b0);
        wait_done();
        check_counters(1, 2, 0);

        // table full
        start_pass();
        for (int i = 10; i <= 17; i++) begin
            add_q.push_back(8'(i));
            send(1'b0, 1'b1, 8'(i), 8'd0, 16'(16'h300 + i), 1'b0, 1'b0);
        end
        send(1'b0, 1'b1, 8'd18, 8'd0, 16'h0312, 1'b0, 1'b1);
        send(1'b1, 1'b0, 8'd18, 8'd10, 16'h1810, 1'b1, 1'b0);
        wait_done();
        check_counters(8, 1, 1);

        // backpressure mid-stream
        start_pass();
        fork
            begin
                send(1'b0, 1'b0, 8'd20, 8'd0, 16'h0420, 1'b0, 1'b1);
                send(1'b0, 1'b0, 8'd21, 8'd0, 16'h0421, 1'b0, 1'b1);
                add_q.push_back(8'd22);
                send(1'b0, 1'b1, 8'd22, 8'd0, 16'h0422, 1'b0, 1'b0);
                send(1'b0, 1'b0, 8'd23, 8'd0, 16'h0423, 1'b0, 1'b1);
                send(1'b1, 1'b0, 8'd20, 8'd22, 16'h2022, 1'b0, 1'b0);
                send(1'b1, 1'b0, 8'd21, 8'd23, 16'h2123, 1'b1, 1'b1);
            end
            begin
                gene_t held;
                repeat (2) @(posedge clk);
                #1 out_ready = 1'b0;
                @(negedge clk);
                held = {out_is_conn, out_id1, out_id2, out_weight, out_last};
                repeat (5) begin
                    @(negedge clk);
                    check("bp_in_ready", 64'(in_ready), 64'h0);
                    check("bp_out_valid", 64'(out_valid), 64'h1);
                    check("bp_out_stable", 64'({out_is_conn, out_id1, out_id2, out_weight, out_last}),
                          64'(held));
                end
                step();
                out_ready = 1'b1;
            end
        join
        wait_done();
        check_counters(1, 1, 0);

        // reset mid-pass with a held output
        start_pass();
        add_q.push_back(8'd30);
        send(1'b0, 1'b1, 8'd30, 8'd0, 16'h0530, 1'b0, 1'b0);
        out_ready = 1'b0;
        send(1'b0, 1'b0, 8'd31, 8'd0, 16'h0531, 1'b0, 1'b1);
        @(negedge clk);
        check("pre_rst_out_valid", 64'(out_valid), 64'h1);
        check("pre_rst_del_count", 64'(del_count), 64'h1);
        step();
        rst = 1'b1;
        step();
        @(negedge clk);
        check("mid_rst_out_valid", 64'(out_valid), 64'h0);
        check("mid_rst_busy", 64'(busy), 64'h0);
        check("mid_rst_out_id1", 64'(out_id1), 64'h0);
        check("mid_rst_tbl_add", 64'(tbl_add), 64'h0);
        check_counters(0, 0, 0);
        step();
        rst = 1'b0;
        out_ready = 1'b1;
        exp_q.delete();
        start_pass();
        send(1'b1, 1'b0, 8'd30, 8'd41, 16'h3041, 1'b1, 1'b1);
        wait_done();
        check_counters(0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
